sfifo_flags: RTL

//  Parametrised single-clock FIFO: configurable width/depth, programmable almost-full/almost-empty,

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ram.sv | 27 ++
 rtl/sfifo_flags.sv | 113 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and a constant-evaluable ceil(log2) helper.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sfifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error bits and
// selectable standard (registered) or first-word-fall-through read data.
module sfifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = FIFO_MODE_STD,
    localparam int unsigned CNT_W   = clog2(DEPTH + 1),
    localparam int unsigned PTR_W   = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic              wrt_en_i,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              clr_err_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    if (DEPTH < 2 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_param_err
        $error("sfifo_flags: need DEPTH>=2 and 0<=AE_LEVEL<AF_LEVEL<=DEPTH");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              rd_acc, wr_acc, clr;
    logic [DATA_W-1:0] ram_rdata;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_acc   = cs_i & rd_en_i & ~empty_o;
        wr_acc   = cs_i & wrt_en_i & (~full_o | rd_acc);
        clr      = cs_i & clr_err_i;
        wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error event wins over a clear in the same cycle.
        ovf_d = (cs_i & wrt_en_i & ~wr_acc) | (ovf_q & ~clr);
        udf_d = (cs_i & rd_en_i & empty_o) | (udf_q & ~clr);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign data_out_o = ram_rdata;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= ram_rdata;
            end
        end
        assign data_out_o = dout_q;
    end

    assign count_o        = count_q;
    assign full_o         = (count_q == CNT_W'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty_o = (count_q <= CNT_W'(AE_LEVEL));
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule
